// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: clock divider, beam position counters, syncs, display enable.
// Optional start-of-frame tick is enabled by defining VGA_FRAME_TICK_EN.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk_i,
    input  logic       reset_i,
    output logic       pix_en_o,
    output logic       VGA_clk_o,
    output logic       hsync_no,
    output logic       vsync_no,
    output logic [9:0] hpos_o,
    output logic [9:0] vpos_o,
    output logic       display_enable_o,
    output logic       frame_start_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DivW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);
    localparam logic [9:0]      HLast   = 10'(H_TOTAL - 1);
    localparam logic [9:0]      VLast   = 10'(V_TOTAL - 1);
    localparam logic [9:0]      HActive = 10'(H_ACTIVE);
    localparam logic [9:0]      VActive = 10'(V_ACTIVE);
    localparam logic [9:0]      HsFirst = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]      HsLast  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]      VsFirst = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]      VsLast  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]      hpos_q, hpos_d;
    logic [9:0]      vpos_q, vpos_d;
    logic            pix_adv;
    logic            pix_en_q, vga_clk_q, hsync_n_q, vsync_n_q, de_q;

    always_comb begin
        pix_adv   = (div_cnt_q == DivLast);
        div_cnt_d = pix_adv ? '0 : div_cnt_q + 1'b1;
        hpos_d    = hpos_q;
        vpos_d    = vpos_q;
        if (pix_adv) begin
            if (hpos_q == HLast) begin
                hpos_d = '0;
                vpos_d = (vpos_q == VLast) ? '0 : vpos_q + 1'b1;
            end else begin
                hpos_d = hpos_q + 1'b1;
            end
        end
    end

    // Every output is decoded from the next-state values so it lines up with hpos_o/vpos_o.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_cnt_q <= '0;
            hpos_q    <= HLast;
            vpos_q    <= VLast;
            pix_en_q  <= 1'b0;
            vga_clk_q <= 1'b0;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            de_q      <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            hpos_q    <= hpos_d;
            vpos_q    <= vpos_d;
            pix_en_q  <= (div_cnt_d == DivLast);
            vga_clk_q <= (div_cnt_d >= DivHalf);
            hsync_n_q <= !((hpos_d >= HsFirst) && (hpos_d <= HsLast));
            vsync_n_q <= !((vpos_d >= VsFirst) && (vpos_d <= VsLast));
            de_q      <= (hpos_d < HActive) && (vpos_d < VActive);
        end
    end

`ifdef VGA_FRAME_TICK_EN
    logic frame_start_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_adv && (hpos_d == '0) && (vpos_d == '0);
        end
    end

    assign frame_start_o = frame_start_q;
`else
    assign frame_start_o = 1'b0;
`endif

    assign pix_en_o         = pix_en_q;
    assign VGA_clk_o        = vga_clk_q;
    assign hsync_no         = hsync_n_q;
    assign vsync_no         = vsync_n_q;
    assign hpos_o           = hpos_q;
    assign vpos_o           = vpos_q;
    assign display_enable_o = de_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-size and shrunken-timing instances against a cycle-count model.
module tb_vga_timing_gen;

    // Small instance keeps whole frames affordable in simulation.
    localparam int SD = 4, SHA = 20, SHF = 3, SHS = 5, SHB = 4;
    localparam int SVA = 10, SVF = 2, SVS = 2, SVB = 3;
    localparam int SFRAME = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB) * SD;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       d_pix, d_vga, d_hs, d_vs, d_de, d_fs;
    logic [9:0] d_h, d_v;
    logic       s_pix, s_vga, s_hs, s_vs, s_de, s_fs;
    logic [9:0] s_h, s_v;

    int checks = 0;
    int failures = 0;
    int k = 0;
    int d_hs_low = 0, d_de_high = 0, s_vs_low = 0, s_last_fs = -1;

    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .clk_i(clk), .reset_i(rst), .pix_en_o(d_pix), .VGA_clk_o(d_vga), .hsync_no(d_hs),
        .vsync_no(d_vs), .hpos_o(d_h), .vpos_o(d_v), .display_enable_o(d_de),
        .frame_start_o(d_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(SD), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) u_small (
        .clk_i(clk), .reset_i(rst), .pix_en_o(s_pix), .VGA_clk_o(s_vga), .hsync_no(s_hs),
        .vsync_no(s_vs), .hpos_o(s_h), .vpos_o(s_v), .display_enable_o(s_de),
        .frame_start_o(s_fs)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at k=%0d: got 0x%0h expected 0x%0h", tag, k, obs, exp);
        end
    endtask

    // Expected {fs, de, vsync_n, hsync_n, vga_clk, pix_en, hpos, vpos} after k clock edges
    // since reset release: n = k/d pixels elapsed from the last pixel of a frame.
    function automatic logic [25:0] model(input int kk, input int d, input int ha, input int hf,
                                          input int hs, input int hb, input int va,
                                          input int vf, input int vs, input int vb);
        int ht, vt, lin, h, v;
        logic fs, de, hsn, vsn, vga, pix;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        lin = (ht * vt - 1 + kk / d) % (ht * vt);
        h   = lin % ht;
        v   = lin / ht;
        pix = ((kk % d) == d - 1);
        vga = ((kk % d) >= d / 2);
        hsn = !(h >= ha + hf && h < ha + hf + hs);
        vsn = !(v >= va + vf && v < va + vf + vs);
        de  = (h < ha) && (v < va);
`ifdef VGA_FRAME_TICK_EN
        fs  = (kk > 0) && ((kk % d) == 0) && (lin == 0);
`else
        fs  = 1'b0;
`endif
        return {fs, de, vsn, hsn, vga, pix, 10'(h), 10'(v)};
    endfunction

    task automatic check_now();
        check_eq("def_outputs", {6'b0, d_fs, d_de, d_vs, d_hs, d_vga, d_pix, d_h, d_v},
                 {6'b0, model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33)});
        check_eq("small_outputs", {6'b0, s_fs, s_de, s_vs, s_hs, s_vga, s_pix, s_h, s_v},
                 {6'b0, model(k, SD, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB)});
    endtask

    task automatic clear_trackers();
        d_hs_low = 0;
        d_de_high = 0;
        s_vs_low = 0;
        s_last_fs = -1;
    endtask

    // Pulse-width and frame-period checks, independent of the per-cycle model.
    task automatic track();
        if (!d_hs) d_hs_low++;
        else if (d_hs_low != 0) begin
            check_eq("hsync_low_cycles", d_hs_low, 192);
            d_hs_low = 0;
        end
        if (d_de) d_de_high++;
        else if (d_de_high != 0) begin
            check_eq("de_high_cycles", d_de_high, 1280);
            d_de_high = 0;
        end
        if (!s_vs) s_vs_low++;
        else if (s_vs_low != 0) begin
            check_eq("vsync_low_cycles", s_vs_low, SVS * (SHA + SHF + SHS + SHB) * SD);
            s_vs_low = 0;
        end
        if (s_fs) begin
            if (s_last_fs >= 0) check_eq("frame_period", k - s_last_fs, SFRAME);
            s_last_fs = k;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            k++;
            check_now();
            track();
        end
    endtask

    // Assert reset asynchronously between edges, check before the next edge, then release.
    task automatic async_reset(input int offset);
        @(negedge clk);
        #(offset);
        rst = 1'b1;
        #1;
        k = 0;
        check_now();
        clear_trackers();
        repeat (3) @(negedge clk);
        check_now();
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        k = 0;
        check_now();
        rst = 1'b0;
        run_cycles(2 * SFRAME + 1700);
        for (int it = 0; it < 6; it++) begin
            async_reset($urandom_range(1, 3));
            run_cycles($urandom_range(50, 2600));
        end
        async_reset(2);
        run_cycles(SFRAME + 10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
